seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Loopback monitor for the multiplexed 7-segment display bus: samples active-low segment and anode lines,
//  decodes each strobed pattern back to a 4-bit digit code and reconstructs the full display value.
//  Sits beside the display driver in the vending machine top level; used for self-test and FPGA-pin checks.
// PARAMETERS
//  NUM_DIGITS     4   number of multiplexed digits / anode lines (1..8)
//  STABLE_CYCLES  4   consecutive identical synced samples needed before a capture (>=2)
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  seg          in   7             segment lines, active-low, bit6=g .. bit0=a
//  an           in   NUM_DIGITS    anode enables, active-low, bit i = digit i
//  digits       out  4*NUM_DIGITS  decoded codes, digit i at [4i+3:4i]
//  digit_ok     out  NUM_DIGITS    bit i high when digit i last captured a legal pattern (0-9 or blank)
//  frame_done   out  1             1-cycle pulse: every digit captured at least once since last pulse
//  err          out  1             1-cycle pulse: illegal pattern or >1 anode low at capture
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low. Reset values: digits all 4'hF, digit_ok 0, frame_done 0,
//    err 0, sync flops all ones (idle bus), run counter 0, seen mask 0, capture-done flag 0.
//  - seg and an pass a 2-flop synchronizer; combined word s={an,seg} taken from second stage.
//  - Run counter counts consecutive cycles with s unchanged, saturating; cleared on any change of s.
//  - Capture fires exactly once per stable period: input held constant from edge 0 -> outputs updated
//    after edge STABLE_CYCLES+2; held fewer cycles -> no capture, no err. No re-capture until s changes.
//  - Pattern table (seg hex -> code): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8,
//    10->9, 7F->F (blank, legal). Any other pattern -> code E, illegal.
//  - At capture, by anode state:
//    . all anodes high: blanking interval; nothing updated, no err.
//    . exactly one low (index i): digits[i]<=code; digit_ok[i]<=legal; seen[i]<=1; err<=!legal.
//    . two or more low: err pulse; digits, digit_ok, seen unchanged.
//  - frame_done: pulses on the cycle after the capture that makes seen all-ones; seen clears to 0 on the
//    same edge, including the just-captured digit. Recapturing an already-seen digit does not pulse.
//  - err and frame_done may pulse in the same cycle; both are single-cycle, registered outputs.
//  - Reset mid-capture: all state returns to reset values immediately; partial runs discarded.
//  - Run counter width: $clog2(STABLE_CYCLES+1); saturates, never wraps.
// STRUCTURE
//  - Shared package seg_pkg: SEG_0..SEG_9, SEG_BLANK pattern constants (shared with encoder side),
//    CODE_BLANK=4'hF, CODE_ERR=4'hE.
//  - Sub-module seg_pattern_decode: combinational 7-bit pattern -> {legal, code[3:0]}.
//  - Top: synchronizer, run counter + capture flag, one-hot anode check, per-digit registers, seen mask.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  - Reset: assert rst_n=0 mid-sim -> digits=16'hFFFF, digit_ok=0, frame_done=0, err=0 same cycle.
//  - Scan 1,2,3,4: an=1110/seg=79, 1101/24, 1011/30, 0111/19, 8 cycles each, 2-cycle all-high gaps
//    -> digits=16'h4321, digit_ok=4'hF, one frame_done pulse after digit 3 capture, err never.
//  - Latency: an=1110, seg=12 held from edge 0 -> digits[3:0]=5 after edge 6, not after edge 5;
//    same pattern held 5 cycles -> no update.
//  - Illegal: an=1011, seg=7'h7E held 8 cycles -> one err pulse, digits[11:8]=E, digit_ok[2]=0.
//  - Ghost: an=1100, seg=40 held 8 cycles -> one err pulse, digits/digit_ok/seen unchanged, no frame_done.
//  - Blank: an=0111, seg=7F -> digits[15:12]=F, digit_ok[3]=1, no err; re-strobe digit 0 only -> no frame_done.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the display encoder and the loopback decoder.
// Patterns are active-low, bit6=g .. bit0=a.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the segment encoder: pattern -> {legal, code}.
// Blank is a legal pattern; anything outside the table decodes to CODE_ERR.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] code
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        legal = 1'b1;
        code  = CODE_ERR;
        unique case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                legal = 1'b0;
                code  = CODE_ERR;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the multiplexed 7-segment bus: synchronizes seg/an, waits for a
// stable strobe, decodes it and rebuilds the displayed value digit by digit.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_done,
    output logic                    err
);

    localparam int W     = NUM_DIGITS + 7;
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [W-1:0]          sync1;
    logic [W-1:0]          s;
    logic [RUN_W-1:0]      run;
    logic                  captured;
    logic [NUM_DIGITS-1:0] seen;

    // Idle bus is all ones (segments off, anodes off), so the synchronizer resets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            s     <= '1;
        end else begin
            // NOTE: non-blocking so each flop samples the other's pre-edge value.
            sync1 <= {an, seg};
            s     <= sync1;
        end
    end

    // s is "unchanged" this cycle when the next value it will load equals its current one;
    // this keeps a capture from firing on a strobe that is already leaving the bus.
    logic stable;
    logic capture;
    assign stable  = (sync1 == s);
    assign capture = stable && !captured && (run == RUN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= '0;
            captured <= 1'b0;
        end else if (!stable) begin
            run      <= '0;
            captured <= 1'b0;
        end else begin
            if (run != RUN_MAX)
                run <= run + 1'b1;
            if (capture)
                captured <= 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] an_low;
    logic                  multi_low;
    logic                  one_low;
    logic                  legal;
    logic [3:0]            code;

    assign an_low    = ~s[W-1:7];
    assign multi_low = (an_low & (an_low - 1'b1)) != '0;
    assign one_low   = (an_low != '0) && !multi_low;

    seg_pattern_decode u_decode (
        .pattern (s[6:0]),
        .legal   (legal),
        .code    (code)
    );

    // NOTE: every register here, including the per-digit store, has an async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits     <= '1;
            digit_ok   <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (capture && one_low) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_low[i]) begin
                        digits[4*i +: 4] <= code;
                        digit_ok[i]      <= legal;
                    end
                end
                err <= !legal;
                if (&(seen | an_low)) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen | an_low;
                end
            end else if (capture && multi_low) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a rising edge.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_ok;
    logic        frame_done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_total = 0;
    int fd_total  = 0;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .digit_ok   (digit_ok),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle; tests compare before/after snapshots.
    always @(negedge clk) begin
        if (err === 1'b1)        err_total++;
        if (frame_done === 1'b1) fd_total++;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (digits !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_digits: got %h expected ffff", digits);
        end
        checks++;
        if (digit_ok !== 4'h0 || frame_done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got ok=%h fd=%b err=%b expected ok=0 fd=0 err=0",
                     digit_ok, frame_done, err);
        end
        rst_n = 1'b1;
        hold(4'hF, 7'h7F, 3);
    endtask

    task automatic test_latency();
        int e0;
        e0 = err_total;
        an  = 4'b1110;
        seg = 7'h12;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) begin
                checks++;
                if (digits[3:0] !== 4'hF) begin
                    failures++;
                    $display("FAIL latency_early: got %h expected f after edge 5", digits[3:0]);
                end
            end
            if (e == 6) begin
                checks++;
                if (digits[3:0] !== 4'h5) begin
                    failures++;
                    $display("FAIL latency_edge6: got %h expected 5 after edge 6", digits[3:0]);
                end
            end
        end
        hold(4'b1110, 7'h12, 2);
        hold(4'hF, 7'h7F, 2);
        hold(4'b1110, 7'h24, 5);
        hold(4'hF, 7'h7F, 10);
        checks++;
        if (digits[3:0] !== 4'h5) begin
            failures++;
            $display("FAIL latency_short_hold: got %h expected 5", digits[3:0]);
        end
        checks++;
        if (err_total != e0) begin
            failures++;
            $display("FAIL latency_err: got %0d pulses expected 0", err_total - e0);
        end
    endtask

    task automatic test_scan();
        int e0;
        int f0;
        e0 = err_total;
        f0 = fd_total;
        hold(4'b1110, 7'h79, 8);
        hold(4'hF, 7'h7F, 2);
        hold(4'b1101, 7'h24, 8);
        hold(4'hF, 7'h7F, 2);
        hold(4'b1011, 7'h30, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (fd_total != f0) begin
            failures++;
            $display("FAIL scan_fd_early: got %0d pulses expected 0 before digit 3", fd_total - f0);
        end
        hold(4'b0111, 7'h19, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (digits !== 16'h4321) begin
            failures++;
            $display("FAIL scan_digits: got %h expected 4321", digits);
        end
        checks++;
        if (digit_ok !== 4'hF) begin
            failures++;
            $display("FAIL scan_ok: got %h expected f", digit_ok);
        end
        checks++;
        if (fd_total - f0 != 1) begin
            failures++;
            $display("FAIL scan_fd: got %0d pulses expected 1", fd_total - f0);
        end
        checks++;
        if (err_total != e0) begin
            failures++;
            $display("FAIL scan_err: got %0d pulses expected 0", err_total - e0);
        end
    endtask

    task automatic test_illegal();
        int e0;
        e0 = err_total;
        hold(4'b1011, 7'h7E, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (err_total - e0 != 1) begin
            failures++;
            $display("FAIL illegal_err: got %0d pulses expected 1", err_total - e0);
        end
        checks++;
        if (digits !== 16'h4E21) begin
            failures++;
            $display("FAIL illegal_digits: got %h expected 4e21", digits);
        end
        checks++;
        if (digit_ok !== 4'b1011) begin
            failures++;
            $display("FAIL illegal_ok: got %b expected 1011", digit_ok);
        end
    endtask

    task automatic test_ghost();
        int e0;
        int f0;
        e0 = err_total;
        f0 = fd_total;
        hold(4'b1100, 7'h40, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (err_total - e0 != 1) begin
            failures++;
            $display("FAIL ghost_err: got %0d pulses expected 1", err_total - e0);
        end
        checks++;
        if (digits !== 16'h4E21 || digit_ok !== 4'b1011) begin
            failures++;
            $display("FAIL ghost_state: got digits=%h ok=%b expected 4e21 1011", digits, digit_ok);
        end
        checks++;
        if (fd_total != f0) begin
            failures++;
            $display("FAIL ghost_fd: got %0d pulses expected 0", fd_total - f0);
        end
    endtask

    // seen holds only digit 2 here, so blank + digit 0 must not complete a frame; digit 1 then does.
    task automatic test_blank();
        int e0;
        int f0;
        e0 = err_total;
        f0 = fd_total;
        hold(4'b0111, 7'h7F, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (digits !== 16'hFE21 || digit_ok !== 4'b1011) begin
            failures++;
            $display("FAIL blank_state: got digits=%h ok=%b expected fe21 1011", digits, digit_ok);
        end
        hold(4'b1110, 7'h40, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (fd_total != f0 || digits !== 16'hFE20) begin
            failures++;
            $display("FAIL blank_restrobe: got fd=%0d digits=%h expected fd=0 digits=fe20",
                     fd_total - f0, digits);
        end
        hold(4'b1101, 7'h78, 8);
        hold(4'hF, 7'h7F, 2);
        checks++;
        if (fd_total - f0 != 1 || digits !== 16'hFE70) begin
            failures++;
            $display("FAIL blank_complete: got fd=%0d digits=%h expected fd=1 digits=fe70",
                     fd_total - f0, digits);
        end
        checks++;
        if (err_total != e0) begin
            failures++;
            $display("FAIL blank_err: got %0d pulses expected 0", err_total - e0);
        end
    endtask

    task automatic test_mid_reset();
        hold(4'b1100, 7'h40, 7);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre_err: got %b expected 1", err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (digits !== 16'hFFFF || digit_ok !== 4'h0 || frame_done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got digits=%h ok=%h fd=%b err=%b expected ffff 0 0 0",
                     digits, digit_ok, frame_done, err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b1110, 7'h10, 3);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        hold(4'b1110, 7'h10, 5);
        checks++;
        if (digits !== 16'hFFFF) begin
            failures++;
            $display("FAIL midreset_partial: got %h expected ffff", digits);
        end
        hold(4'b1110, 7'h10, 4);
        checks++;
        if (digits !== 16'hFFF9 || digit_ok !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_recover: got digits=%h ok=%b expected fff9 0001", digits, digit_ok);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_illegal();
        test_ghost();
        test_blank();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
